// File: rtl/relu_pkg.sv
// Shared types and lane geometry for the ReLU job controller.
// No logic; constants and the controller FSM encoding only.
package relu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } relu_ctrl_state_t;

    localparam int RELU_LANES  = 7;
    localparam int RELU_LANE_W = 32;
    localparam int RELU_DW     = RELU_LANES * RELU_LANE_W;

endpackage

// File: rtl/relu_ctrl_pipe.sv
// Two-stage valid tracker: buffer read data (v1) and ReLU register (v2).
// Latency: read strobe to write valid is 2 cycles.
// Backpressure: both stages freeze whenever v2 is held and wr_ready is low.
module relu_ctrl_pipe (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_en,
    input  logic wr_ready,
    output logic adv,
    output logic v1,
    output logic relu_en,
    output logic wr_en
);

    logic v1_q;
    logic v2_q;

    assign adv = !v2_q || wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (adv) begin
            v2_q <= v1_q;
            v1_q <= rd_en;
        end
    end

    assign v1      = v1_q;
    assign relu_en = adv && v1_q;
    assign wr_en   = v2_q;

endmodule

// File: rtl/relu_ctrl.sv
// Job controller streaming len beats buffer -> ReLU -> feature-map buffer.
// Latency: start to done is len+3 cycles (1 cycle for len=0) plus stall cycles.
// Backpressure: wr_ready low with wr_en freezes the whole job; RELU_CTRL_STALL_CNT_EN adds stall_cnt.
module relu_ctrl
    import relu_pkg::*;
#(
    parameter int DW    = 224,
    parameter int AW    = 10,
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    rd_base,
    input  logic [AW-1:0]    wr_base,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    output logic             relu_en,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    input  logic             wr_ready,
    output logic [31:0]      stall_cnt
);

    relu_ctrl_state_t state_q, state_d;
    logic [LEN_W-1:0] rem_q;
    logic [AW-1:0]    rd_addr_q;
    logic [AW-1:0]    wr_addr_q;
    logic             adv;
    logic             v1;
    logic             accept;

    relu_ctrl_pipe u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .wr_ready (wr_ready),
        .adv      (adv),
        .v1       (v1),
        .relu_en  (relu_en),
        .wr_en    (wr_en)
    );

    assign accept = (state_q == ST_IDLE) && start;
    assign rd_en  = (state_q == ST_RUN) && adv && (rem_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // DRAIN exits as soon as the pipeline will be empty next cycle, so done lands at len+3.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (rd_en && rem_q == LEN_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (!v1 && adv) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else if (accept) begin
            rem_q     <= len;
            rd_addr_q <= rd_base;
            wr_addr_q <= wr_base;
        end else begin
            if (rd_en) begin
                rem_q     <= rem_q - LEN_W'(1);
                rd_addr_q <= rd_addr_q + AW'(1);
            end
            if (wr_en && wr_ready) wr_addr_q <= wr_addr_q + AW'(1);
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign rd_addr = rd_addr_q;
    assign wr_addr = wr_addr_q;

`ifdef RELU_CTRL_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                stall_q <= '0;
        else if (accept)                                           stall_q <= '0;
        else if (wr_en && !wr_ready && stall_q != 32'hFFFF_FFFF)   stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        assert (DW == RELU_DW) else $error("relu_ctrl: DW does not match lane geometry");
    end

endmodule
